tlb_maint_ctrl: RTL and testbench
=================================

# tlb_maint_ctrl

Sequencer for TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) in front of the register-based TLB entry array inside the MMU. It accepts one maintenance request at a time from the commit stage. It walks the entry array through a single combinational read port, one entry per cycle, and produces the one-hot `tlb_write_req_t` that the MMU applies to its entry registers. It returns one response per request: hit/index/entry data for CSR update, or an invalid-op error.

## Interface
- `TLB_ENTRY_NUM`, 64: number of TLB entries; must be a power of two.
- `IDX_W`, `$clog2(TLB_ENTRY_NUM)`: entry index width.

- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in 1: maintenance request present.
- `req_ready` out 1: controller idle, so the request is accepted this cycle.
- `req_op` in 3: operation code. 0 = SRCH, 1 = RD, 2 = WR, 3 = FILL, 4 = INV, 5–7 = reserved.
- `req_inv_op` in 5: INVTLB op field.
- `req_asid` in 10: ASID operand, used by SRCH and INV.
- `req_va` in 32: VA operand. SRCH uses TLBEHI.VPPN placed at `va[31:13]`; INV uses the rk value.
- `req_index` in IDX_W: TLBIDX.INDEX, used by RD and WR.
- `req_entry` in `tlb_entry_t`: entry to write, used by WR and FILL.
- `rd_idx` out IDX_W: read-port index.
- `rd_entry` in `tlb_entry_t`: entry at `rd_idx`, available in the same cycle.
- `tlb_write_req_o` out `tlb_write_req_t`: one-hot write enable plus write entry.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_found` out 1: SRCH hit, or RD of an entry with `e=1`.
- `resp_index` out IDX_W: hit index for SRCH; echoed index for RD.
- `resp_entry` out `tlb_entry_t`: entry read by RD.
- `resp_err` out 1: reserved `req_op`, or INV with `req_inv_op` > 6.

## Operation
- States: IDLE, SCAN_SRCH, SCAN_INV, RD, WRITE, RESP.
- `req_ready` = (state == IDLE). A request is accepted on `req_valid && req_ready`, and all operands are registered at accept.
- Transitions on accept:
  - SRCH → SCAN_SRCH
  - INV with `req_inv_op` ≤ 6 → SCAN_INV
  - RD → RD
  - WR and FILL → WRITE
  - reserved op or bad `req_inv_op` → RESP with `resp_err=1`
- Scan counter `scan_q` (IDX_W) is cleared at accept. `rd_idx` = `scan_q` in scan states and the registered index in RD.
- Match rule per entry, all conditions required:
  - `e=1`
  - VPPN compare: `va[31:22]==vppn[18:9]` if `huge_page`, else `va[31:13]==vppn`
  - ASID compare: `g || asid==req_asid`
- SCAN_SRCH: on match, latch `scan_q` as the hit index and go to RESP. If there is no match at index N-1, go to RESP with `resp_found=0`. The lowest matching index wins.
- SCAN_INV: each cycle, evaluate the predicate selected by `req_inv_op` against `rd_entry`:
  - 0/1: all entries
  - 2: `g=1`
  - 3: `g=0`
  - 4: `g=0 && asid match`
  - 5: `g=0 && asid match && VPPN match`
  - 6: `(g=1 || asid match) && VPPN match`
  
  If the predicate is true, drive a one-hot write at `scan_q` with `rd_entry`, `key.e` forced to 0 and all other fields unchanged, in the same cycle. After index N-1, go to RESP.
- RD: capture `rd_entry` and go to RESP. `resp_found = rd_entry.key.e`. `resp_entry` is the captured entry, forwarded as-is.
- WRITE: assert one-hot write for one cycle with `req_entry`, then go to RESP.
  - WR targets `req_index`.
  - FILL targets the free-running counter value latched at accept.
- FILL counter: IDX_W bits, reset 0, +1 every cycle regardless of state, wraps N-1 → 0.
- RESP: `resp_valid=1` for one cycle, then go to IDLE.
- `tlb_write_req_o` is all-zero in every cycle not listed above; at most one bit is set per cycle.

## Timing
- Reset values:
  - state IDLE, `req_ready=1`, `resp_valid=0`, all response fields 0
  - `tlb_write_req_o` one-hot = 0
  - `scan_q=0`, FILL counter 0
- Accept at cycle T. Response pulse at:
  - RD: T+2
  - WR/FILL: write at T+1, response at T+2
  - SRCH hit at index k: T+2+k
  - SRCH miss: T+1+N
  - INV: writes in cycles T+1..T+N, response at T+N+1
  - error: T+1
- No new request is accepted until the cycle after `resp_valid`, when state is IDLE again.
- An INV write at index i does not affect the scan of other indices. The array updates at the edge after the write cycle.
- `rst` in any state, including mid-scan: the next cycle is IDLE, no write is issued that cycle, and no response is given for the aborted request.

## Test plan
- Reset, then idle 5 cycles → `req_ready=1`, no write bits, `resp_valid=0`.
- WR `req_index`=5 with e=1, vppn=0x12345, asid=3, g=0 at T → bit 5 of the write one-hot set at T+1 only. RD index 5 → `resp_found=1` and `resp_entry` equals the written entry at T+2.
- SRCH va=0x2468A000, asid=3, with entries 9 and 20 matching → `resp_index=9`, `resp_found=1` at T+11. With no match → `resp_found=0` at T+65.
- Huge-page entry (vppn=0x7FE00, `huge_page=1`, g=1) at index 40; SRCH va=0xFFFFF000 with any asid → hit index 40.
- INV op 4, asid=3, over entries {2: g=0 asid 3; 7: g=1 asid 3; 11: g=0 asid 4} → writes with e=0 to index 2 only, response at T+65. INV op 9 → `resp_err=1` at T+1 and no writes.
- Assert `rst` at T+10 of an INV → IDLE at T+11, no further writes, no response. FILL issued at counter value 63 → write at index 63, and the counter then wraps to 0.

Source files
------------

// File: rtl/tlb_maint_ctrl.sv
// rtl/tlb_maint_ctrl.sv - TLB maintenance sequencer (SRCH/RD/WR/FILL/INV) over a one-read-port entry array

package tlb_maint_pkg;

  localparam int PKG_TLB_ENTRY_NUM = 64;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic        huge_page;
    logic        g;
    logic [9:0]  asid;
  } tlb_key_t;

  typedef struct packed {
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_data_t;

  typedef struct packed {
    tlb_key_t  key;
    tlb_data_t data;
  } tlb_entry_t;

  // One-hot write enable is sized by the package; the controller's
  // TLB_ENTRY_NUM must match it.
  typedef struct packed {
    logic [PKG_TLB_ENTRY_NUM-1:0] we;
    tlb_entry_t                   entry;
  } tlb_write_req_t;

endpackage

module tlb_maint_ctrl #(
  parameter int TLB_ENTRY_NUM = tlb_maint_pkg::PKG_TLB_ENTRY_NUM,
  parameter int IDX_W         = $clog2(TLB_ENTRY_NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_op,
  input  logic [4:0]                    req_inv_op,
  input  logic [9:0]                    req_asid,
  input  logic [31:0]                   req_va,
  input  logic [IDX_W-1:0]              req_index,
  input  tlb_maint_pkg::tlb_entry_t     req_entry,
  output logic [IDX_W-1:0]              rd_idx,
  input  tlb_maint_pkg::tlb_entry_t     rd_entry,
  output tlb_maint_pkg::tlb_write_req_t tlb_write_req_o,
  output logic                          resp_valid,
  output logic                          resp_found,
  output logic [IDX_W-1:0]              resp_index,
  output tlb_maint_pkg::tlb_entry_t     resp_entry,
  output logic                          resp_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN_SRCH, S_SCAN_INV, S_RD, S_WRITE, S_RESP
  } state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRY_NUM - 1);

  state_t                    state_q, state_d;
  logic [4:0]                inv_op_q, inv_op_d;
  logic [9:0]                asid_q, asid_d;
  logic [18:0]               va_q, va_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  tlb_maint_pkg::tlb_entry_t wentry_q, wentry_d;
  logic [IDX_W-1:0]          scan_q, scan_d;
  logic [IDX_W-1:0]          fill_cnt_q, fill_cnt_d;
  logic                      resp_found_q, resp_found_d;
  logic [IDX_W-1:0]          resp_index_q, resp_index_d;
  tlb_maint_pkg::tlb_entry_t resp_entry_q, resp_entry_d;
  logic                      resp_err_q, resp_err_d;

  logic                      vppn_match;
  logic                      asid_match;
  logic                      srch_hit;
  logic                      inv_hit;
  logic [TLB_ENTRY_NUM-1:0]  wr_onehot;
  tlb_maint_pkg::tlb_entry_t wr_entry;

  // Page offset bits of the VA operand carry no meaning for either lookup.
  logic va_low_unused;
  assign va_low_unused = ^req_va[12:0];

  // Match terms of the entry on the read port against the registered operands
  always_comb begin
    vppn_match = rd_entry.key.huge_page ? (va_q[18:9] == rd_entry.key.vppn[18:9])
                                        : (va_q == rd_entry.key.vppn);
    asid_match = (rd_entry.key.asid == asid_q);
    srch_hit   = rd_entry.key.e && vppn_match && (rd_entry.key.g || asid_match);
    inv_hit    = 1'b0;
    case (inv_op_q)
      5'd0, 5'd1: inv_hit = 1'b1;
      5'd2:       inv_hit = rd_entry.key.g;
      5'd3:       inv_hit = !rd_entry.key.g;
      5'd4:       inv_hit = !rd_entry.key.g && asid_match;
      5'd5:       inv_hit = !rd_entry.key.g && asid_match && vppn_match;
      5'd6:       inv_hit = (rd_entry.key.g || asid_match) && vppn_match;
      default:    inv_hit = 1'b0;
    endcase
  end

  // Next-state, operand capture, scan stepping and write generation
  always_comb begin
    state_d      = state_q;
    inv_op_d     = inv_op_q;
    asid_d       = asid_q;
    va_d         = va_q;
    idx_d        = idx_q;
    wentry_d     = wentry_q;
    scan_d       = scan_q;
    fill_cnt_d   = fill_cnt_q + 1'b1;
    resp_found_d = resp_found_q;
    resp_index_d = resp_index_q;
    resp_entry_d = resp_entry_q;
    resp_err_d   = resp_err_q;
    wr_onehot    = '0;
    wr_entry     = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          inv_op_d     = req_inv_op;
          asid_d       = req_asid;
          va_d         = req_va[31:13];
          // FILL picks its victim from the free-running counter at accept.
          idx_d        = (req_op == OP_FILL) ? fill_cnt_q : req_index;
          wentry_d     = req_entry;
          scan_d       = '0;
          resp_found_d = 1'b0;
          resp_index_d = '0;
          resp_entry_d = '0;
          resp_err_d   = 1'b0;
          case (req_op)
            OP_SRCH:        state_d = S_SCAN_SRCH;
            OP_RD:          state_d = S_RD;
            OP_WR, OP_FILL: state_d = S_WRITE;
            OP_INV: begin
              if (req_inv_op <= 5'd6) begin
                state_d = S_SCAN_INV;
              end else begin
                resp_err_d = 1'b1;
                state_d    = S_RESP;
              end
            end
            default: begin
              resp_err_d = 1'b1;
              state_d    = S_RESP;
            end
          endcase
        end
      end
      S_SCAN_SRCH: begin
        if (srch_hit) begin
          resp_found_d = 1'b1;
          resp_index_d = scan_q;
          state_d      = S_RESP;
        end else if (scan_q == LAST_IDX) begin
          state_d = S_RESP;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      S_SCAN_INV: begin
        if (inv_hit) begin
          wr_onehot[scan_q] = 1'b1;
          wr_entry          = rd_entry;
          wr_entry.key.e    = 1'b0;
        end
        if (scan_q == LAST_IDX) begin
          state_d = S_RESP;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      S_RD: begin
        resp_entry_d = rd_entry;
        resp_found_d = rd_entry.key.e;
        resp_index_d = idx_q;
        state_d      = S_RESP;
      end
      S_WRITE: begin
        wr_onehot[idx_q] = 1'b1;
        wr_entry         = wentry_q;
        state_d          = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A reset cycle must never leak a half-finished invalidation into the array.
    if (rst) begin
      wr_onehot = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      inv_op_q     <= '0;
      asid_q       <= '0;
      va_q         <= '0;
      idx_q        <= '0;
      wentry_q     <= '0;
      scan_q       <= '0;
      fill_cnt_q   <= '0;
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
      resp_entry_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      inv_op_q     <= inv_op_d;
      asid_q       <= asid_d;
      va_q         <= va_d;
      idx_q        <= idx_d;
      wentry_q     <= wentry_d;
      scan_q       <= scan_d;
      fill_cnt_q   <= fill_cnt_d;
      resp_found_q <= resp_found_d;
      resp_index_q <= resp_index_d;
      resp_entry_q <= resp_entry_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready             = (state_q == S_IDLE);
  assign resp_valid            = (state_q == S_RESP);
  assign rd_idx                = (state_q == S_RD) ? idx_q : scan_q;
  assign tlb_write_req_o.we    = wr_onehot;
  assign tlb_write_req_o.entry = wr_entry;
  assign resp_found            = resp_found_q;
  assign resp_index            = resp_index_q;
  assign resp_entry            = resp_entry_q;
  assign resp_err              = resp_err_q;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// tb/tb_tlb_maint_ctrl.sv - self-checking bench for tlb_maint_ctrl against a behavioural TLB model

module tb_tlb_maint_ctrl;
  import tlb_maint_pkg::*;

  localparam int N = 64;
  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     req_op;
  logic [4:0]     req_inv_op;
  logic [9:0]     req_asid;
  logic [31:0]    req_va;
  logic [5:0]     req_index;
  tlb_entry_t     req_entry;
  logic [5:0]     rd_idx;
  tlb_entry_t     rd_entry;
  tlb_write_req_t wreq;
  logic           resp_valid;
  logic           resp_found;
  logic [5:0]     resp_index;
  tlb_entry_t     resp_entry;
  logic           resp_err;

  tlb_maint_ctrl #(.TLB_ENTRY_NUM(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_inv_op(req_inv_op), .req_asid(req_asid), .req_va(req_va),
    .req_index(req_index), .req_entry(req_entry), .rd_idx(rd_idx), .rd_entry(rd_entry),
    .tlb_write_req_o(wreq), .resp_valid(resp_valid), .resp_found(resp_found),
    .resp_index(resp_index), .resp_entry(resp_entry), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // MMU entry array as seen by the controller, and the bench's own copy of what it should hold
  tlb_entry_t mem [N];
  tlb_entry_t ref_mem [N];
  logic       mem_clr;
  logic [5:0] fcnt;

  assign rd_entry = mem[rd_idx];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mem_clr) mem[i] <= '0;
      else if (wreq.we[i]) mem[i] <= wreq.entry;
    end
  end

  always @(posedge clk) fcnt <= rst ? 6'd0 : fcnt + 6'd1;

  int n_chk, n_err;

  int         e_resp_cyc, o_resp_cyc;
  logic       e_found, o_found, e_err, o_err;
  logic [5:0] e_index, o_index;
  tlb_entry_t e_entry, o_entry;
  int         ew_idx[$], ew_cyc[$], ow_idx[$], ow_cyc[$];
  tlb_entry_t ew_ent[$], ow_ent[$];
  int         o_multi;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tlb_entry_t mk(input logic e, input logic [18:0] vppn, input logic hp,
                                    input logic g, input logic [9:0] asid);
    tlb_entry_t  t;
    logic [63:0] r;
    r = {$urandom, $urandom};
    t.data          = r[51:0];
    t.key.e         = e;
    t.key.vppn      = vppn;
    t.key.huge_page = hp;
    t.key.g         = g;
    t.key.asid      = asid;
    return t;
  endfunction

  function automatic tlb_entry_t rnd_entry();
    return mk(1'($urandom), 19'($urandom), 1'b0, 1'($urandom), 10'($urandom_range(8, 1023)));
  endfunction

  function automatic bit vppn_hit(input tlb_entry_t t, input logic [31:0] va);
    if (t.key.huge_page) return va[31:22] == t.key.vppn[18:9];
    return va[31:13] == t.key.vppn;
  endfunction

  function automatic bit inv_sel(input int op, input tlb_entry_t t, input logic [9:0] asid,
                                 input logic [31:0] va);
    bit am, vm, g;
    am = (t.key.asid == asid);
    vm = vppn_hit(t, va);
    g  = t.key.g;
    case (op)
      0, 1:    return 1'b1;
      2:       return g;
      3:       return !g;
      4:       return !g && am;
      5:       return !g && am && vm;
      6:       return (g || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outcome of one request, in cycles after the accept cycle; effects beyond max_cyc are dropped
  task automatic model_op(input logic [2:0] op, input logic [4:0] inv_op, input logic [9:0] asid,
                          input logic [31:0] va, input logic [5:0] idx, input tlb_entry_t ent,
                          input int max_cyc);
    int         rc;
    logic [5:0] tgt;
    tlb_entry_t t;
    e_found = 1'b0; e_index = '0; e_entry = '0; e_err = 1'b0;
    ew_idx.delete(); ew_cyc.delete(); ew_ent.delete();
    rc = 1;
    case (op)
      OP_SRCH: begin
        rc = N + 1;
        for (int i = 0; i < N; i++) begin
          t = ref_mem[i];
          if (!e_found && t.key.e && vppn_hit(t, va) && (t.key.g || t.key.asid == asid)) begin
            e_found = 1'b1; e_index = 6'(i); rc = 2 + i;
          end
        end
      end
      OP_RD: begin
        rc = 2; e_found = ref_mem[idx].key.e; e_index = idx; e_entry = ref_mem[idx];
      end
      OP_WR, OP_FILL: begin
        rc  = 2;
        tgt = (op == OP_FILL) ? fcnt : idx;
        if (max_cyc >= 1) begin
          ew_idx.push_back(int'(tgt)); ew_cyc.push_back(1); ew_ent.push_back(ent);
          ref_mem[tgt] = ent;
        end
      end
      OP_INV: begin
        if (inv_op <= 5'd6) begin
          rc = N + 1;
          for (int i = 0; i < N; i++) begin
            if (inv_sel(int'(inv_op), ref_mem[i], asid, va) && (i + 1) <= max_cyc) begin
              t = ref_mem[i]; t.key.e = 1'b0; ref_mem[i] = t;
              ew_idx.push_back(i); ew_cyc.push_back(i + 1); ew_ent.push_back(t);
            end
          end
        end else begin
          e_err = 1'b1;
        end
      end
      default: e_err = 1'b1;
    endcase
    e_resp_cyc = (rc <= max_cyc) ? rc : -1;
  endtask

  // Issue one request (called just after a falling edge) and log writes/response for up to lim cycles
  task automatic run_op(input logic [2:0] op, input logic [4:0] inv_op, input logic [9:0] asid,
                        input logic [31:0] va, input logic [5:0] idx, input tlb_entry_t ent,
                        input int lim);
    chk("ready_before_req", 128'(req_ready), 128'(1));
    req_valid = 1'b1; req_op = op; req_inv_op = inv_op; req_asid = asid;
    req_va = va; req_index = idx; req_entry = ent;
    o_resp_cyc = -1; o_found = 1'b0; o_index = '0; o_entry = '0; o_err = 1'b0; o_multi = 0;
    ow_idx.delete(); ow_cyc.delete(); ow_ent.delete();
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (wreq.we != '0) begin
        if ($countones(wreq.we) != 1) o_multi++;
        for (int i = 0; i < N; i++) begin
          if (wreq.we[i]) begin
            ow_idx.push_back(i); ow_cyc.push_back(c); ow_ent.push_back(wreq.entry);
          end
        end
      end
      if (resp_valid) begin
        o_resp_cyc = c; o_found = resp_found; o_index = resp_index;
        o_entry = resp_entry; o_err = resp_err;
        break;
      end
    end
    if (o_resp_cyc > 0) begin
      @(negedge clk);
      chk("resp_single_pulse", 128'(resp_valid), 128'(0));
    end
  endtask

  task automatic cmp_op(input string tag, input logic [2:0] op);
    int bad;
    chk({tag, ":resp_cycle"}, 128'(o_resp_cyc), 128'(e_resp_cyc));
    chk({tag, ":err"}, 128'(o_err), 128'(e_err));
    if (op == OP_SRCH || op == OP_RD) chk({tag, ":found"}, 128'(o_found), 128'(e_found));
    if ((op == OP_SRCH && e_found) || op == OP_RD) chk({tag, ":index"}, 128'(o_index), 128'(e_index));
    if (op == OP_RD) chk({tag, ":entry"}, 128'(o_entry), 128'(e_entry));
    chk({tag, ":write_count"}, 128'(ow_idx.size()), 128'(ew_idx.size()));
    bad = 0;
    for (int i = 0; i < ew_idx.size() && i < ow_idx.size(); i++) begin
      if (ow_idx[i] != ew_idx[i] || ow_cyc[i] != ew_cyc[i] || ow_ent[i] !== ew_ent[i]) bad++;
    end
    chk({tag, ":write_list"}, 128'(bad), 128'(0));
    chk({tag, ":onehot"}, 128'(o_multi), 128'(0));
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, ":array"}, 128'(bad), 128'(0));
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [4:0] inv_op,
                       input logic [9:0] asid, input logic [31:0] va, input logic [5:0] idx,
                       input tlb_entry_t ent);
    model_op(op, inv_op, asid, va, idx, ent, 1000);
    run_op(op, inv_op, asid, va, idx, ent, N + 10);
    cmp_op(tag, op);
  endtask

  initial begin
    tlb_entry_t  ent;
    int          j, act;
    logic [31:0] va;
    logic [9:0]  asid;
    int          inv_ops[4];

    n_chk = 0; n_err = 0;
    rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; req_op = '0; req_inv_op = '0;
    req_asid = '0; req_va = '0; req_index = '0; req_entry = '0;
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle:ready", 128'(req_ready), 128'(1));
      chk("idle:we", 128'(wreq.we), 128'(0));
      chk("idle:resp_valid", 128'(resp_valid), 128'(0));
      if (k == 0) begin
        chk("reset:resp_found", 128'(resp_found), 128'(0));
        chk("reset:resp_index", 128'(resp_index), 128'(0));
        chk("reset:resp_err", 128'(resp_err), 128'(0));
        chk("reset:resp_entry", 128'(resp_entry), 128'(0));
      end
    end

    ent = mk(1'b1, 19'h12345, 1'b0, 1'b0, 10'd3);
    do_op("wr5", OP_WR, 5'd0, 10'd0, 32'd0, 6'd5, ent);
    do_op("rd5", OP_RD, 5'd0, 10'd0, 32'd0, 6'd5, '0);

    for (int i = 0; i < N; i++) begin
      if (i != 5) do_op("wr_rand", OP_WR, 5'd0, 10'd0, 32'd0, 6'(i), rnd_entry());
    end
    for (int k = 0; k < 4; k++) do_op("rd_rand", OP_RD, 5'd0, 10'd0, 32'd0, 6'($urandom), '0);

    do_op("wr5b", OP_WR, 5'd0, 10'd0, 32'd0, 6'd5, mk(1'b1, 19'h12345, 1'b0, 1'b0, 10'd4));
    do_op("wr9", OP_WR, 5'd0, 10'd0, 32'd0, 6'd9, mk(1'b1, 19'h12345, 1'b0, 1'b0, 10'd3));
    do_op("wr20", OP_WR, 5'd0, 10'd0, 32'd0, 6'd20, mk(1'b1, 19'h12345, 1'b0, 1'b1, 10'd77));
    do_op("srch_hit9", OP_SRCH, 5'd0, 10'd3, 32'h2468A000, 6'd0, '0);
    do_op("srch_global20", OP_SRCH, 5'd0, 10'd55, 32'h2468A000, 6'd0, '0);
    do_op("srch_miss", OP_SRCH, 5'd0, 10'd3, 32'h13579000, 6'd0, '0);

    do_op("wr40_huge", OP_WR, 5'd0, 10'd0, 32'd0, 6'd40, mk(1'b1, 19'h7FE00, 1'b1, 1'b1, 10'd200));
    do_op("srch_huge", OP_SRCH, 5'd0, 10'($urandom), 32'hFFFFF000, 6'd0, '0);

    for (int k = 0; k < 5; k++) begin
      j    = $urandom_range(0, N - 1);
      va   = {ref_mem[j].key.vppn, 13'($urandom)};
      asid = ($urandom_range(0, 1) == 1) ? ref_mem[j].key.asid : 10'($urandom);
      do_op("srch_rand", OP_SRCH, 5'd0, asid, va, 6'd0, '0);
    end

    do_op("wr2", OP_WR, 5'd0, 10'd0, 32'd0, 6'd2, mk(1'b1, 19'($urandom), 1'b0, 1'b0, 10'd3));
    do_op("wr7", OP_WR, 5'd0, 10'd0, 32'd0, 6'd7, mk(1'b1, 19'($urandom), 1'b0, 1'b1, 10'd3));
    do_op("wr11", OP_WR, 5'd0, 10'd0, 32'd0, 6'd11, mk(1'b1, 19'($urandom), 1'b0, 1'b0, 10'd4));
    do_op("inv4", OP_INV, 5'd4, 10'd3, 32'd0, 6'd0, '0);

    do_op("inv9_err", OP_INV, 5'd9, 10'd3, 32'd0, 6'd0, '0);
    do_op("inv7_err", OP_INV, 5'd7, 10'd3, 32'd0, 6'd0, '0);
    for (int op = 5; op < 8; op++) do_op("rsvd_op", 3'(op), 5'd0, 10'd0, 32'd0, 6'd0, '0);

    inv_ops = '{2, 3, 5, 6};
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 4; m++) begin
        ent = mk(1'b1, 19'($urandom), 1'b0, 1'($urandom),
                 ($urandom_range(0, 1) == 1) ? 10'd3 : 10'($urandom));
        do_op("wr_refresh", OP_WR, 5'd0, 10'd0, 32'd0, 6'($urandom), ent);
      end
      j  = $urandom_range(0, N - 1);
      va = {ref_mem[j].key.vppn, 13'($urandom)};
      do_op("inv_rand", OP_INV, 5'(inv_ops[k]), ref_mem[j].key.asid, va, 6'd0, '0);
    end

    // Reset in the middle of an invalidate-all: nine writes land, the tenth is suppressed
    model_op(OP_INV, 5'd0, 10'd0, 32'd0, 6'd0, '0, 9);
    run_op(OP_INV, 5'd0, 10'd0, 32'd0, 6'd0, '0, 9);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort:we_in_rst_cycle", 128'(wreq.we), 128'(0));
    chk("abort:resp_in_rst_cycle", 128'(resp_valid), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort:idle_ready", 128'(req_ready), 128'(1));
    chk("abort:resp_found_cleared", 128'(resp_found), 128'(0));
    act = 0;
    for (int k = 0; k < N + 6; k++) begin
      if (wreq.we != '0 || resp_valid) act++;
      @(negedge clk);
    end
    chk("abort:no_later_activity", 128'(act), 128'(0));
    cmp_op("abort", OP_INV);

    for (int k = 0; k < 2 * N && fcnt != 6'd63; k++) @(negedge clk);
    do_op("fill63", OP_FILL, 5'd0, 10'd0, 32'd0, 6'd0, rnd_entry());
    for (int k = 0; k < 2 * N && fcnt != 6'd0; k++) @(negedge clk);
    do_op("fill0_wrap", OP_FILL, 5'd0, 10'd0, 32'd0, 6'd0, rnd_entry());
    repeat ($urandom_range(1, 20)) @(negedge clk);
    do_op("fill_rand", OP_FILL, 5'd0, 10'd0, 32'd0, 6'd0, rnd_entry());
    do_op("rd63", OP_RD, 5'd0, 10'd0, 32'd0, 6'd63, '0);
    do_op("rd0", OP_RD, 5'd0, 10'd0, 32'd0, 6'd0, '0);
    do_op("inv0_all", OP_INV, 5'd0, 10'd0, 32'd0, 6'd0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
